// File: rtl/cola_buyer.sv
// Buyer-side initiator for the cola vending machine: inserts coins per cola using a
// selectable coin policy, waits for the cola pulse, and tallies colas, change and money paid.
module cola_buyer #(
  parameter int PRICE_HALF = 5,
  parameter int TIMEOUT    = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [3:0] order_num,
  input  logic [1:0] pay_mode,
  output logic       po_money_half,
  output logic       po_money_one,
  input  logic       pi_cola,
  input  logic       pi_change,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] cola_cnt,
  output logic [4:0] change_cnt,
  output logic [7:0] paid_cnt
);
  localparam logic [7:0] PRICE = 8'(PRICE_HALF);
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_PAY, S_WAIT, S_NEXT, S_DONE, S_ERR} state_t;

  state_t     r_state, w_nx_state;
  logic       r_half, r_one, r_busy, r_done, r_err;
  logic [3:0] r_cola, r_order;
  logic [4:0] r_change;
  logic [7:0] r_paid, r_credit, r_timer;
  logic [1:0] r_mode;

  logic       w_nx_half, w_nx_one, w_nx_busy, w_nx_done, w_nx_err;
  logic [3:0] w_nx_cola, w_nx_order;
  logic [4:0] w_nx_change;
  logic [7:0] w_nx_paid, w_nx_credit, w_nx_timer;
  logic [1:0] w_nx_mode;

  logic [7:0] w_coin, w_credit_add;
  logic [8:0] w_paid_sum;
  logic       w_one_new, w_one_next, w_one_cont;

  // A one-coin is chosen while at least a full unit is still owed (greedy), or always/never.
  function automatic logic f_use_one(input logic [1:0] mode, input logic [7:0] credit);
    logic [7:0] rem;
    rem = PRICE - credit;
    case (mode)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      default: return (rem >= 8'd2);
    endcase
  endfunction

  // The coin on the outputs this cycle is accounted for at the end of the cycle.
  assign w_coin       = r_one ? 8'd2 : (r_half ? 8'd1 : 8'd0);
  assign w_credit_add = r_credit + w_coin;
  assign w_paid_sum   = {1'b0, r_paid} + {1'b0, w_coin};
  assign w_one_new    = f_use_one(pay_mode, 8'd0);
  assign w_one_next   = f_use_one(r_mode, 8'd0);
  assign w_one_cont   = f_use_one(r_mode, w_credit_add);

  always_comb begin
    w_nx_state  = r_state;
    w_nx_half   = 1'b0;
    w_nx_one    = 1'b0;
    w_nx_busy   = r_busy;
    w_nx_done   = 1'b0;
    w_nx_err    = r_err;
    w_nx_cola   = r_cola;
    w_nx_change = r_change;
    w_nx_paid   = r_paid;
    w_nx_credit = r_credit;
    w_nx_timer  = r_timer;
    w_nx_order  = r_order;
    w_nx_mode   = r_mode;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          w_nx_order  = order_num;
          w_nx_mode   = pay_mode;
          w_nx_cola   = '0;
          w_nx_change = '0;
          w_nx_paid   = '0;
          w_nx_credit = '0;
          w_nx_timer  = '0;
          w_nx_err    = 1'b0;
          if (order_num == 4'd0) begin
            w_nx_state = S_DONE;
            w_nx_done  = 1'b1;
            w_nx_busy  = 1'b0;
          end else begin
            w_nx_state = S_PAY;
            w_nx_busy  = 1'b1;
            w_nx_one   = w_one_new;
            w_nx_half  = ~w_one_new;
          end
        end else if (r_state == S_DONE) begin
          w_nx_state = S_IDLE;
        end
      end
      S_PAY: begin
        w_nx_credit = w_credit_add;
        w_nx_paid   = w_paid_sum[8] ? 8'hFF : w_paid_sum[7:0];
        if (pi_cola) begin
          w_nx_state = S_ERR;
          w_nx_err   = 1'b1;
          w_nx_busy  = 1'b0;
        end else if (w_credit_add >= PRICE) begin
          w_nx_state = S_WAIT;
          w_nx_timer = '0;
        end else begin
          w_nx_one  = w_one_cont;
          w_nx_half = ~w_one_cont;
        end
      end
      S_WAIT: begin
        if (pi_change && r_change != 5'd31) w_nx_change = r_change + 5'd1;
        if (pi_cola) begin
          if (r_cola != r_order) w_nx_cola = r_cola + 4'd1;
          w_nx_state = S_NEXT;
        end else if (r_timer == TLAST) begin
          w_nx_state = S_ERR;
          w_nx_err   = 1'b1;
          w_nx_busy  = 1'b0;
        end else begin
          w_nx_timer = r_timer + 8'd1;
        end
      end
      S_NEXT: begin
        if (r_cola == r_order) begin
          w_nx_state = S_DONE;
          w_nx_done  = 1'b1;
          w_nx_busy  = 1'b0;
        end else begin
          w_nx_credit = '0;
          w_nx_state  = S_PAY;
          w_nx_one    = w_one_next;
          w_nx_half   = ~w_one_next;
        end
      end
      default: w_nx_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state  <= S_IDLE;
      r_half   <= 1'b0;
      r_one    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_cola   <= '0;
      r_change <= '0;
      r_paid   <= '0;
      r_credit <= '0;
      r_timer  <= '0;
      r_order  <= '0;
      r_mode   <= '0;
    end else begin
      r_state  <= w_nx_state;
      r_half   <= w_nx_half;
      r_one    <= w_nx_one;
      r_busy   <= w_nx_busy;
      r_done   <= w_nx_done;
      r_err    <= w_nx_err;
      r_cola   <= w_nx_cola;
      r_change <= w_nx_change;
      r_paid   <= w_nx_paid;
      r_credit <= w_nx_credit;
      r_timer  <= w_nx_timer;
      r_order  <= w_nx_order;
      r_mode   <= w_nx_mode;
    end
  end

  assign po_money_half = r_half;
  assign po_money_one  = r_one;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign cola_cnt      = r_cola;
  assign change_cnt    = r_change;
  assign paid_cnt      = r_paid;
endmodule

// File: tb/tb_cola_buyer.sv
// Directed bench for cola_buyer: a small machine model answers coins with cola/change pulses.
module tb_cola_buyer;
  localparam int PRICE = 5;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] order_num = '0;
  logic [1:0] pay_mode = '0;
  logic       pi_cola = 1'b0;
  logic       pi_change = 1'b0;
  logic       po_money_half, po_money_one, busy, done, err;
  logic [3:0] cola_cnt;
  logic [4:0] change_cnt;
  logic [7:0] paid_cnt;

  int checks = 0;
  int failures = 0;

  cola_buyer #(.PRICE_HALF(PRICE), .TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .order_num(order_num),
    .pay_mode(pay_mode), .po_money_half(po_money_half), .po_money_one(po_money_one),
    .pi_cola(pi_cola), .pi_change(pi_change), .busy(busy), .done(done), .err(err),
    .cola_cnt(cola_cnt), .change_cnt(change_cnt), .paid_cnt(paid_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [3:0] n, input logic [1:0] m);
    @(negedge sys_clk);
    start = 1'b1; order_num = n; pay_mode = m;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  // Count coins until they stop, then answer with cola (and change if overpaid).
  task automatic serve(input string tag, input int exp_ones, input int exp_halves);
    int  ones = 0, halves = 0, sum = 0;
    bit  served = 1'b0, overlap = 1'b0;
    for (int c = 0; c < 24 && !served; c++) begin
      if (po_money_half && po_money_one) overlap = 1'b1;
      if (po_money_one) begin
        ones++; sum += 2; @(negedge sys_clk);
      end else if (po_money_half) begin
        halves++; sum += 1; @(negedge sys_clk);
      end else if (sum > 0) begin
        pi_cola = 1'b1; pi_change = (sum > PRICE);
        @(negedge sys_clk);
        pi_cola = 1'b0; pi_change = 1'b0;
        served = 1'b1;
      end else begin
        @(negedge sys_clk);
      end
    end
    chk({tag, "_served"}, int'(served), 1);
    chk({tag, "_ones"}, ones, exp_ones);
    chk({tag, "_halves"}, halves, exp_halves);
    chk({tag, "_overlap"}, int'(overlap), 0);
  endtask

  // Called at the NEXT-state negedge right after the last cola.
  task automatic finish(input string tag, input int cola, input int change, input int paid);
    chk({tag, "_done_early"}, int'(done), 0);
    @(negedge sys_clk);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_cola"}, int'(cola_cnt), cola);
    chk({tag, "_change"}, int'(change_cnt), change);
    chk({tag, "_paid"}, int'(paid_cnt), paid);
    @(negedge sys_clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int bad;
    repeat (2) @(negedge sys_clk);
    chk("rst_coins", int'({po_money_half, po_money_one}), 0);
    chk("rst_flags", int'({busy, done, err}), 0);
    chk("rst_cnts", int'({cola_cnt, change_cnt, paid_cnt}), 0);
    sys_rst_n = 1'b1;

    // Mode 1, one cola: three one-coins, overpaid by one half-unit.
    do_start(4'd1, 2'd1);
    chk("m1_busy", int'(busy), 1);
    serve("m1", 3, 0);
    finish("m1", 1, 1, 6);

    // Mode 0, two colas of five halves each.
    do_start(4'd2, 2'd0);
    serve("m0a", 0, 5);
    serve("m0b", 0, 5);
    finish("m0", 2, 0, 10);

    // Mode 2 (greedy), three colas: one, one, half each.
    do_start(4'd3, 2'd2);
    serve("m2a", 2, 1);
    serve("m2b", 2, 1);
    serve("m2c", 2, 1);
    finish("m2", 3, 0, 15);

    // Timeout: five halves, then eight silent WAIT cycles.
    do_start(4'd1, 2'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (po_money_half !== 1'b1) bad++;
      @(negedge sys_clk);
    end
    chk("to_coins", bad, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (err !== 1'b0 || busy !== 1'b1 || po_money_half || po_money_one) bad++;
      @(negedge sys_clk);
    end
    chk("to_wait", bad, 0);
    chk("to_err", int'(err), 1);
    chk("to_busy", int'(busy), 0);
    chk("to_coins0", int'({po_money_half, po_money_one}), 0);
    chk("to_paid", int'(paid_cnt), 5);
    @(negedge sys_clk);
    chk("to_sticky", int'(err), 1);
    do_start(4'd1, 2'd1);
    chk("to_clr", int'(err), 0);
    serve("to_m1", 3, 0);
    finish("to_m1", 1, 1, 6);

    // Zero-length order: done the cycle after start, no coins.
    do_start(4'd0, 2'd2);
    chk("z_done", int'(done), 1);
    chk("z_coins", int'({po_money_half, po_money_one}), 0);
    chk("z_paid", int'(paid_cnt), 0);
    @(negedge sys_clk);
    chk("z_pulse", int'(done), 0);

    // Start while busy must not disturb the latched order or mode.
    do_start(4'd2, 2'd1);
    serve("bz_a", 3, 0);
    start = 1'b1; order_num = 4'd5; pay_mode = 2'd0;
    @(negedge sys_clk);
    start = 1'b0;
    chk("bz_cola", int'(cola_cnt), 1);
    serve("bz_b", 3, 0);
    finish("bz", 2, 2, 12);

    // Async reset during PAY, then the same order from scratch.
    do_start(4'd1, 2'd0);
    @(negedge sys_clk);
    chk("ar_pre_paid", int'(paid_cnt), 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("ar_coins", int'({po_money_half, po_money_one}), 0);
    chk("ar_flags", int'({busy, done, err}), 0);
    chk("ar_paid", int'(paid_cnt), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    do_start(4'd1, 2'd0);
    serve("ar_m0", 0, 5);
    finish("ar", 1, 0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
